// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared-ALU arbiter.
// Transfers use valid/ready: a beat moves on a rising edge where both are high.
interface alu_arbiter_if;
    logic        i_req0_valid;
    logic        i_req1_valid;
    logic [31:0] i_req0_operandA;
    logic [31:0] i_req1_operandA;
    logic [31:0] i_req0_operandB;
    logic [31:0] i_req1_operandB;
    logic [3:0]  i_req0_aluOp;
    logic [3:0]  i_req1_aluOp;
    logic        o_req0_ready;
    logic        o_req1_ready;
    logic        o_rsp0_valid;
    logic        o_rsp1_valid;
    logic [31:0] o_rsp0_data;
    logic [31:0] o_rsp1_data;
    logic        i_rsp0_ready;
    logic        i_rsp1_ready;
    logic [7:0]  o_grant0_cnt;
    logic [7:0]  o_grant1_cnt;

    modport master (
        output i_req0_valid, i_req1_valid, i_req0_operandA, i_req1_operandA,
               i_req0_operandB, i_req1_operandB, i_req0_aluOp, i_req1_aluOp,
               i_rsp0_ready, i_rsp1_ready,
        input  o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
               o_rsp0_data, o_rsp1_data, o_grant0_cnt, o_grant1_cnt
    );

    modport slave (
        input  i_req0_valid, i_req1_valid, i_req0_operandA, i_req1_operandA,
               i_req0_operandB, i_req1_operandB, i_req0_aluOp, i_req1_aluOp,
               i_rsp0_ready, i_rsp1_ready,
        output o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
               o_rsp0_data, o_rsp1_data, o_grant0_cnt, o_grant1_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one combinational ALU; round-robin grant with a one-deep
// result slot per requester, plus per-requester accepted-transfer counters.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] y
);
    // Encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
    // 8 SLT, 9 SLTU; unused codes return zero.
    always_comb begin
        y = 32'd0;
        case (op)
            4'd0: y = a + b;
            4'd1: y = a - b;
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = a << b[4:0];
            4'd6: y = a >> b[4:0];
            4'd7: y = $signed(a) >>> b[4:0];
            4'd8: y = {31'd0, $signed(a) < $signed(b)};
            4'd9: y = {31'd0, a < b};
            default: y = 32'd0;
        endcase
    end
endmodule

module alu_arbiter (
    input  logic         i_clk,
    input  logic         i_reset,
    alu_arbiter_if.slave bus
);
    logic        ptr_q, ptr_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp0_data_q, rsp0_data_d;
    logic [31:0] rsp1_data_q, rsp1_data_d;
    logic [7:0]  grant0_cnt_q, grant0_cnt_d;
    logic [7:0]  grant1_cnt_q, grant1_cnt_d;

    logic        elig0, elig1, grant0, grant1;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_op;

    // A slot counts as free when it is empty or being drained this same cycle.
    always_comb begin
        elig0  = bus.i_req0_valid && (!rsp0_valid_q || bus.i_rsp0_ready);
        elig1  = bus.i_req1_valid && (!rsp1_valid_q || bus.i_rsp1_ready);
        grant0 = i_reset && elig0 && (!elig1 || !ptr_q);
        grant1 = i_reset && elig1 && (!elig0 || ptr_q);
    end

    always_comb begin
        alu_a  = grant1 ? bus.i_req1_operandA : bus.i_req0_operandA;
        alu_b  = grant1 ? bus.i_req1_operandB : bus.i_req0_operandB;
        alu_op = grant1 ? bus.i_req1_aluOp    : bus.i_req0_aluOp;
    end

    alu u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    always_comb begin
        ptr_d        = ptr_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        grant0_cnt_d = grant0_cnt_q;
        grant1_cnt_d = grant1_cnt_q;
        if (grant0) ptr_d = 1'b1;
        if (grant1) ptr_d = 1'b0;
        // A new result overrides a drain, so back-to-back results have no bubble.
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_y;
            grant0_cnt_d = grant0_cnt_q + 8'd1;
        end else if (bus.i_rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_y;
            grant1_cnt_d = grant1_cnt_q + 8'd1;
        end else if (bus.i_rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ptr_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 32'd0;
            rsp1_data_q  <= 32'd0;
            grant0_cnt_q <= 8'd0;
            grant1_cnt_q <= 8'd0;
        end else begin
            ptr_q        <= ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
        end
    end

    assign bus.o_req0_ready = grant0;
    assign bus.o_req1_ready = grant1;
    assign bus.o_rsp0_valid = rsp0_valid_q;
    assign bus.o_rsp1_valid = rsp1_valid_q;
    assign bus.o_rsp0_data  = rsp0_data_q;
    assign bus.o_rsp1_data  = rsp1_data_q;
    assign bus.o_grant0_cnt = grant0_cnt_q;
    assign bus.o_grant1_cnt = grant1_cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: drivers push hand-computed results into per-requester
// queues, a negedge monitor pops and compares whenever a response appears.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_BAD = 4'd15;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic i_clk;
    logic i_reset;
    alu_arbiter_if bus ();

    alu_arbiter dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;
    vec_t v0[4];
    vec_t v1[4];
    int glog[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic present0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        bus.i_req0_valid = 1'b1;
        bus.i_req0_aluOp = op;
        bus.i_req0_operandA = a;
        bus.i_req0_operandB = b;
        exp0_q.push_back(exp);
    endtask

    task automatic present1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        bus.i_req1_valid = 1'b1;
        bus.i_req1_aluOp = op;
        bus.i_req1_operandA = a;
        bus.i_req1_operandB = b;
        exp1_q.push_back(exp);
    endtask

    task automatic do_reset();
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        i_reset = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready0"}, {31'd0, bus.o_req0_ready}, 32'd0);
        check({tag, "_ready1"}, {31'd0, bus.o_req1_ready}, 32'd0);
        check({tag, "_rsp0_valid"}, {31'd0, bus.o_rsp0_valid}, 32'd0);
        check({tag, "_rsp1_valid"}, {31'd0, bus.o_rsp1_valid}, 32'd0);
        check({tag, "_rsp0_data"}, bus.o_rsp0_data, 32'd0);
        check({tag, "_rsp1_data"}, bus.o_rsp1_data, 32'd0);
        check({tag, "_cnt0"}, {24'd0, bus.o_grant0_cnt}, 32'd0);
        check({tag, "_cnt1"}, {24'd0, bus.o_grant1_cnt}, 32'd0);
    endtask

    // Monitor: a beat accepted at one edge must show up as a response before the next negedge.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            if (pend0) begin
                check("rsp0_valid_after_xfer", {31'd0, bus.o_rsp0_valid}, 32'd1);
                if (exp0_q.size() == 0) check("rsp0_unexpected", bus.o_rsp0_data, 32'hxxxxxxxx);
                else check("rsp0_data", bus.o_rsp0_data, exp0_q.pop_front());
            end
            if (pend1) begin
                check("rsp1_valid_after_xfer", {31'd0, bus.o_rsp1_valid}, 32'd1);
                if (exp1_q.size() == 0) check("rsp1_unexpected", bus.o_rsp1_data, 32'hxxxxxxxx);
                else check("rsp1_data", bus.o_rsp1_data, exp1_q.pop_front());
            end
            pend0 <= bus.o_req0_ready && bus.i_req0_valid;
            pend1 <= bus.o_req1_ready && bus.i_req1_valid;
        end
    end

    initial begin
        int i0, i1, cyc;
        logic g0, g1;
        v0[0] = '{OP_ADD, 32'd1, 32'd2, 32'd3};
        v0[1] = '{OP_SUB, 32'd10, 32'd3, 32'd7};
        v0[2] = '{OP_AND, 32'h0000f0f0, 32'h0000ff00, 32'h0000f000};
        v0[3] = '{OP_OR, 32'h0000000f, 32'h000000f0, 32'h000000ff};
        v1[0] = '{OP_XOR, 32'h000000ff, 32'h0000000f, 32'h000000f0};
        v1[1] = '{OP_SLL, 32'd1, 32'd4, 32'h00000010};
        v1[2] = '{OP_SRL, 32'h00000080, 32'd3, 32'h00000010};
        v1[3] = '{OP_SRA, 32'h80000000, 32'd4, 32'hf8000000};

        i_reset = 1'b0;
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_req0_operandA = '0;
        bus.i_req0_operandB = '0;
        bus.i_req0_aluOp = '0;
        bus.i_req1_operandA = '0;
        bus.i_req1_operandB = '0;
        bus.i_req1_aluOp = '0;
        bus.i_rsp0_ready = 1'b1;
        bus.i_rsp1_ready = 1'b1;

        // Reset state, with valids high to show ready stays low.
        #3;
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        #1;
        check_all_zero("reset");
        do_reset();

        // Single ADD from requester 0.
        present0(OP_ADD, 32'd5, 32'd7, 32'd12);
        @(negedge i_clk);
        check("add_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
        check("add_ready1_idle", {31'd0, bus.o_req1_ready}, 32'd0);
        step();
        bus.i_req0_valid = 1'b0;
        check("add_rsp0_valid", {31'd0, bus.o_rsp0_valid}, 32'd1);
        check("add_rsp0_data", bus.o_rsp0_data, 32'd12);
        check("add_cnt0", {24'd0, bus.o_grant0_cnt}, 32'd1);
        step();

        // Both requesters always valid: strict alternation starting at 0.
        do_reset();
        glog.delete();
        i0 = 0;
        i1 = 0;
        cyc = 0;
        present0(v0[0].op, v0[0].a, v0[0].b, v0[0].exp);
        present1(v1[0].op, v1[0].a, v1[0].b, v1[0].exp);
        while ((i0 < 4 || i1 < 4) && cyc < 40) begin
            @(negedge i_clk);
            g0 = bus.o_req0_ready && bus.i_req0_valid;
            g1 = bus.o_req1_ready && bus.i_req1_valid;
            glog.push_back(g0 ? 0 : (g1 ? 1 : 2));
            step();
            cyc++;
            if (g0) begin
                i0++;
                if (i0 < 4) present0(v0[i0].op, v0[i0].a, v0[i0].b, v0[i0].exp);
                else bus.i_req0_valid = 1'b0;
            end
            if (g1) begin
                i1++;
                if (i1 < 4) present1(v1[i1].op, v1[i1].a, v1[i1].b, v1[i1].exp);
                else bus.i_req1_valid = 1'b0;
            end
        end
        if (cyc >= 40) check("rr_timeout", 32'(cyc), 32'd0);
        check("rr_log_len", 32'(glog.size()), 32'd8);
        for (int k = 0; k < glog.size() && k < 8; k++)
            check("rr_grant_order", 32'(glog[k]), 32'(k % 2));
        check("rr_cnt0", {24'd0, bus.o_grant0_cnt}, 32'd4);
        check("rr_cnt1", {24'd0, bus.o_grant1_cnt}, 32'd4);

        // Back-pressure on requester 1: it is blocked, requester 0 granted every cycle.
        bus.i_rsp1_ready = 1'b0;
        present1(OP_SLT, 32'hffffffff, 32'd1, 32'd1);
        present0(OP_ADD, 32'hffffffff, 32'd1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("bp_ready1", {31'd0, bus.o_req1_ready}, 32'd0);
            check("bp_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
            check("bp_rsp1_hold", bus.o_rsp1_data, 32'hf8000000);
            step();
            if (k == 0) present0(OP_SUB, 32'd0, 32'd1, 32'hffffffff);
            else if (k == 1) present0(OP_BAD, 32'd9, 32'd9, 32'd0);
            else bus.i_req0_valid = 1'b0;
        end
        bus.i_rsp1_ready = 1'b1;
        @(negedge i_clk);
        check("bp_release_ready1", {31'd0, bus.o_req1_ready}, 32'd1);
        step();
        present1(OP_SLTU, 32'hffffffff, 32'd1, 32'd0);
        @(negedge i_clk);
        check("bp_drain_and_refill", {31'd0, bus.o_req1_ready}, 32'd1);
        step();
        bus.i_req1_valid = 1'b0;
        step();

        // Held result replaced by a new one on the drain edge; ignored inputs while blocked.
        bus.i_rsp0_ready = 1'b0;
        present0(OP_ADD, 32'd100, 32'd1, 32'd101);
        @(negedge i_clk);
        check("hold_first_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
        step();
        bus.i_req0_aluOp = OP_ADD;
        bus.i_req0_operandA = 32'd999;
        @(negedge i_clk);
        check("hold_backpressure_ready0", {31'd0, bus.o_req0_ready}, 32'd0);
        check("hold_data", bus.o_rsp0_data, 32'd101);
        step();
        bus.i_rsp0_ready = 1'b1;
        present0(OP_SUB, 32'd10, 32'd3, 32'd7);
        @(negedge i_clk);
        check("hold_drain_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
        step();
        bus.i_req0_valid = 1'b0;
        check("nobubble_valid", {31'd0, bus.o_rsp0_valid}, 32'd1);
        check("nobubble_data", bus.o_rsp0_data, 32'd7);
        step();
        check("drain_valid", {31'd0, bus.o_rsp0_valid}, 32'd0);
        check("drain_data_kept", bus.o_rsp0_data, 32'd7);

        // 256 requester-1 transfers wrap its counter.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            present1(OP_ADD, 32'(k), 32'd1, 32'(k + 1));
            step();
            if (k == 254) check("cnt1_255", {24'd0, bus.o_grant1_cnt}, 32'd255);
        end
        bus.i_req1_valid = 1'b0;
        check("cnt1_wrap", {24'd0, bus.o_grant1_cnt}, 32'd0);

        // Reset mid-stream clears everything before the next edge.
        present0(OP_ADD, 32'd2, 32'd3, 32'd5);
        present1(OP_ADD, 32'd7, 32'd8, 32'd15);
        step();
        #2;
        i_reset = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        #1;
        check_all_zero("midreset");
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        step();
        i_reset = 1'b1;
        present0(OP_ADD, 32'd2, 32'd2, 32'd4);
        step();
        bus.i_req0_valid = 1'b0;
        check("resume_cnt0", {24'd0, bus.o_grant0_cnt}, 32'd1);
        check("resume_cnt1", {24'd0, bus.o_grant1_cnt}, 32'd0);
        check("resume_rsp0_data", bus.o_rsp0_data, 32'd4);
        repeat (2) step();

        check("exp0_q_empty", 32'(exp0_q.size()), 32'd0);
        check("exp1_q_empty", 32'(exp1_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
